// File: rtl/sc_shuffle.sv
// Serial-commutator FFT shuffle: re-pairs lanes DELAY accepted samples apart; outputs registered, latency DELAY samples + 1 clk.
// Define SC_SHUFFLE_FRAME_CHECK_EN to flag sof arriving at a nonzero sample count on frame_err.
package sc_shuffle_pkg;
  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } complex_t;
endpackage

module sc_shuffle
  import sc_shuffle_pkg::*;
#(
  parameter int DELAY = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     sof,
  input  logic     in_valid,
  input  complex_t din,
  output logic     out_valid,
  output complex_t dout,
  output logic     sw_out,
  output logic     frame_err
);
  localparam int CW = $clog2(2 * DELAY);
  localparam int AW = (DELAY > 1) ? $clog2(DELAY) : 1;

  logic [CW-1:0] cnt_q, cnt_d, cnt_base;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          primed_q, primed_d;
  logic          ptr_last;
  logic          s;
  logic [15:0]   bd, xa, x, y;

  // Both delay lines share one circular pointer; reading before the write at
  // the same slot yields the word written DELAY accepted samples earlier.
  logic [15:0] mem_a [DELAY];
  logic [15:0] mem_b [DELAY];

  logic     out_valid_q;
  complex_t dout_q;
  logic     sw_q;

  always_comb begin
    cnt_base = sof ? '0 : cnt_q;
    s        = cnt_base[CW-1];
    ptr_last = (ptr_q == AW'(DELAY - 1));
    bd       = mem_b[ptr_q];
    xa       = mem_a[ptr_q];
    x        = s ? bd : din.re;
    y        = s ? din.re : bd;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    primed_d = primed_q;
    if (in_valid) begin
      cnt_d = cnt_base + CW'(1);
      ptr_d = ptr_last ? '0 : ptr_q + AW'(1);
      if (ptr_last) primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_b[ptr_q] <= din.im;
      mem_a[ptr_q] <= x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      ptr_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sw_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      primed_q    <= primed_d;
      out_valid_q <= in_valid && primed_q;
      if (in_valid) begin
        dout_q.re <= xa;
        dout_q.im <= y;
        sw_q      <= s;
      end
    end
  end

`ifdef SC_SHUFFLE_FRAME_CHECK_EN
  logic frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= in_valid && sof && (cnt_q != '0);
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sw_out    = sw_q;
endmodule

// File: tb/tb_sc_shuffle.sv
// Bench for sc_shuffle at DELAY = 1, 2, 4 and 1024 sharing one input stream; one DUT is observed per phase.
module tb_sc_shuffle;
  import sc_shuffle_pkg::*;

  typedef struct {
    logic        vld;
    logic        full;
    logic [15:0] re;
    logic [15:0] im;
    logic        sw;
    logic        fe;
  } exp_t;

`ifdef SC_SHUFFLE_FRAME_CHECK_EN
  localparam bit FE_ON = 1'b1;
`else
  localparam bit FE_ON = 1'b0;
`endif

  logic     clk;
  logic     rst;
  logic     sof;
  logic     in_valid;
  complex_t din;
  logic [3:0] ov;
  logic [3:0] swo;
  logic [3:0] fe;
  complex_t   dq [4];

  int checks   = 0;
  int failures = 0;
  int sel      = 1;
  exp_t sb[$];

  int ml = 4;
  int m_cnt = 0;
  int m_n = 0;
  logic [15:0] m_im[$];
  logic [15:0] m_x[$];

  int a_re [8] = '{0, 0, 0, 1, 100, 101, 4, 5};
  int a_im [8] = '{0, 0, 2, 3, 102, 103, 6, 7};
  int a_sw [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
  int b_re [5] = '{0, 0, 50, 2, 52};
  int b_im [5] = '{0, 1, 51, 3, 53};
  int b_sw [5] = '{0, 1, 0, 1, 0};

  sc_shuffle #(.DELAY(1)) u_l1 (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid), .din(din),
    .out_valid(ov[0]), .dout(dq[0]), .sw_out(swo[0]), .frame_err(fe[0])
  );
  sc_shuffle #(.DELAY(2)) u_l2 (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid), .din(din),
    .out_valid(ov[1]), .dout(dq[1]), .sw_out(swo[1]), .frame_err(fe[1])
  );
  sc_shuffle #(.DELAY(4)) u_l4 (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid), .din(din),
    .out_valid(ov[2]), .dout(dq[2]), .sw_out(swo[2]), .frame_err(fe[2])
  );
  sc_shuffle #(.DELAY(1024)) u_l1024 (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid), .din(din),
    .out_valid(ov[3]), .dout(dq[3]), .sw_out(swo[3]), .frame_err(fe[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic vld, input logic full, input logic [15:0] re,
                              input logic [15:0] im, input logic sw, input logic fe_e);
    exp_t e;
    e.vld = vld; e.full = full; e.re = re; e.im = im; e.sw = sw; e.fe = fe_e;
    return e;
  endfunction

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s dut=%s observed=%0h expected=%0h", tag, $sformatf("%0d", sel), obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk1("out_valid", 32'(ov[sel]), 32'(e.vld));
    chk1("frame_err", 32'(fe[sel]), 32'(e.fe));
    if (e.vld || e.full) begin
      chk1("dout_re", 32'(dq[sel].re), 32'(e.re));
      chk1("dout_im", 32'(dq[sel].im), 32'(e.im));
      chk1("sw_out", 32'(swo[sel]), 32'(e.sw));
    end
  endtask

  task automatic step(input logic r, input logic sf, input logic v, input logic [15:0] re,
                      input logic [15:0] im, input exp_t e);
    rst = r; sof = sf; in_valid = v; din.re = re; din.im = im;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic reset_step();
    m_cnt = 0;
    m_n = 0;
    m_im.delete();
    m_x.delete();
    step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, mk(1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0));
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, mk(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0));
  endtask

  // Reference model written directly from the sample-index equations.
  task automatic model_step(input logic sf, input logic v, input logic [15:0] re,
                            input logic [15:0] im, output exp_t e);
    int c;
    logic s;
    logic [15:0] bd, x, y;
    e = mk(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    if (v) begin
      c  = sf ? 0 : m_cnt;
      s  = (c >= ml);
      bd = (m_n >= ml) ? m_im[m_n - ml] : 16'd0;
      x  = s ? bd : re;
      y  = s ? re : bd;
      m_im.push_back(im);
      m_x.push_back(x);
      e.vld = (m_n >= ml);
      e.re  = e.vld ? m_x[m_n - ml] : 16'd0;
      e.im  = y;
      e.sw  = s;
      e.fe  = FE_ON && sf && (m_cnt != 0);
      m_cnt = (c + 1) % (2 * ml);
      m_n++;
    end
  endtask

  task automatic mstep(input logic sf, input logic v, input logic [15:0] re, input logic [15:0] im);
    exp_t e;
    model_step(sf, v, re, im, e);
    step(1'b0, sf, v, re, im, e);
  endtask

  task automatic run_a(input bit gaps, input int last);
    for (int n = 0; n <= last; n++) begin
      if (gaps && n == 5) begin
        for (int g = 0; g < 3; g++) idle_step();
      end
      step(1'b0, n == 0, 1'b1, 16'(n), 16'(100 + n),
           mk(n >= 2, 1'b0, 16'(a_re[n]), 16'(a_im[n]), a_sw[n][0], 1'b0));
    end
  endtask

  initial begin
    rst = 1'b1; sof = 1'b0; in_valid = 1'b0; din = '0;

    // DELAY=2 directed stream, then with a 3-cycle gap, then reset mid-frame.
    sel = 1;
    reset_step();
    run_a(1'b0, 7);
    reset_step();
    run_a(1'b1, 7);
    reset_step();
    run_a(1'b0, 5);
    reset_step();
    run_a(1'b0, 7);

    // DELAY=1: swap phase alternates every sample.
    sel = 0;
    reset_step();
    for (int n = 0; n <= 4; n++) begin
      step(1'b0, n == 0, 1'b1, 16'(n), 16'(50 + n),
           mk(n >= 1, 1'b0, 16'(b_re[n]), 16'(b_im[n]), b_sw[n][0], 1'b0));
    end

    // DELAY=4: sof at cnt=3 realigns (and pulses frame_err when enabled); sof at cnt=0 does not.
    sel = 2;
    ml = 4;
    reset_step();
    mstep(1'b1, 1'b1, 16'd200, 16'd300);
    mstep(1'b0, 1'b1, 16'd201, 16'd301);
    mstep(1'b0, 1'b1, 16'd202, 16'd302);
    mstep(1'b1, 1'b1, 16'd203, 16'd303);
    for (int k = 4; k < 11; k++) mstep(1'b0, 1'b1, 16'(200 + k), 16'(300 + k));
    mstep(1'b1, 1'b1, 16'd211, 16'd311);
    for (int k = 12; k < 20; k++) mstep(1'b0, 1'b1, 16'(200 + k), 16'(300 + k));
    idle_step();

    // DELAY=1024: long random run with random gaps.
    sel = 3;
    ml = 1024;
    reset_step();
    for (int k = 0; k < 5000; k++) begin
      while ($urandom_range(0, 3) == 0) mstep(1'b0, 1'b0, 16'd0, 16'd0);
      mstep(k == 0, 1'b1, 16'($urandom), 16'($urandom));
    end
    idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
